// File: rtl/sm_pkg.sv
// Shared types for the sm_* clock-control blocks: core-clock modes and FSM states.
package sm_pkg;

    typedef enum logic [1:0] {
        SM_MODE_RUN   = 2'd0,
        SM_MODE_HALT  = 2'd1,
        SM_MODE_STEP  = 2'd2,
        SM_MODE_BURST = 2'd3
    } sm_mode_e;

    typedef enum logic [1:0] {
        SM_ST_PARK  = 2'd0,
        SM_ST_RUN   = 2'd1,
        SM_ST_STEP  = 2'd2,
        SM_ST_BURST = 2'd3
    } sm_state_e;

endpackage

// File: rtl/sm_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by a rising-edge pulse.
module sm_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Core clock generator for sm_arm: divided clkOut plus run/halt/single-step/burst control.
// state | meaning
// PARK  | no core edges granted; clkOut completes its phase and parks low
// RUN   | free-running core clock
// STEP  | grant exactly one core edge
// BURST | grant burstLen core edges, counted down on each tickEn
module sm_clk_ctrl
    import sm_pkg::*;
#(
    parameter int DIV_W  = 5,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clkIn,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  clkDevide,
    input  logic [1:0]        mode,
    input  logic              stepReq,
    input  logic [STEP_W-1:0] burstLen,
    input  logic              clkEnable,
    output logic              clkOut,
    output logic              tickEn,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycleCount
);

    sm_state_e         r_state;
    sm_state_e         w_state_nxt;
    sm_mode_e          w_mode;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [STEP_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic              r_clk_out;
    logic              w_step_edge;
    logic              w_tc;
    logic              w_fire;
    logic              w_run_ok;
    logic              w_burst_last;
    logic              w_grant;
    logic              w_tick;
    logic              w_done;
    logic              w_burst_load;

    assign w_mode = sm_mode_e'(mode);

    sm_sync_edge u_step_sync (
        .i_clk   (clkIn),
        .i_rst_n (rst_n),
        .i_async (stepReq),
        .o_rise  (w_step_edge)
    );

    // Phase timer runs down from clkDevide; zero is terminal count and it parks there.
    assign w_tc         = (r_div_cnt == '0);
    assign w_fire       = w_tc & ~r_clk_out;
    assign w_run_ok     = (w_mode == SM_MODE_RUN) & clkEnable;
    assign w_burst_last = (r_burst_cnt == STEP_W'(1));
    assign w_tick       = w_fire & w_grant;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        w_burst_load = 1'b0;
        unique case (r_state)
            SM_ST_PARK: begin
                if (w_run_ok) begin
                    w_state_nxt = SM_ST_RUN;
                end else if (w_step_edge && w_mode == SM_MODE_STEP) begin
                    w_state_nxt = SM_ST_STEP;
                end else if (w_step_edge && w_mode == SM_MODE_BURST) begin
                    if (burstLen != '0) begin
                        w_state_nxt  = SM_ST_BURST;
                        w_burst_load = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            SM_ST_RUN: begin
                w_grant = w_run_ok;
                if (w_fire && !w_run_ok) begin
                    w_state_nxt = SM_ST_PARK;
                end
            end
            SM_ST_STEP: begin
                if (w_mode == SM_MODE_STEP) begin
                    w_grant = clkEnable;
                    if (w_fire && clkEnable) begin
                        w_done      = 1'b1;
                        w_state_nxt = SM_ST_PARK;
                    end
                end else if (w_mode != SM_MODE_HALT) begin
                    w_state_nxt = SM_ST_PARK;
                end
            end
            SM_ST_BURST: begin
                // HALT or clkEnable=0 freezes here with the count intact; other modes abort.
                if (w_mode == SM_MODE_BURST) begin
                    w_grant = clkEnable;
                    if (w_fire && clkEnable && w_burst_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = SM_ST_PARK;
                    end
                end else if (w_mode != SM_MODE_HALT) begin
                    w_state_nxt = SM_ST_PARK;
                end
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SM_ST_PARK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (w_burst_load) begin
            r_burst_cnt <= burstLen;
        end else if (r_state == SM_ST_BURST && w_tick) begin
            r_burst_cnt <= r_burst_cnt - STEP_W'(1);
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_out   <= 1'b0;
            r_div_cnt   <= '0;
            r_cycle_cnt <= '0;
        end else if (!w_tc) begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
        end else if (r_clk_out) begin
            r_clk_out <= 1'b0;
            r_div_cnt <= clkDevide;
        end else if (w_grant) begin
            r_clk_out   <= 1'b1;
            r_div_cnt   <= clkDevide;
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign clkOut     = r_clk_out;
    assign tickEn     = w_tick;
    assign done       = w_done;
    assign busy       = (r_state != SM_ST_PARK) & clkEnable & (w_mode != SM_MODE_HALT);
    assign cycleCount = r_cycle_cnt;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Bench for sm_clk_ctrl: directed latency/corner sequences, a table of one-shot requests,
// and a randomized run against an edge-budget reference model.
`timescale 1ns/1ps
module tb_sm_clk_ctrl;

    localparam int DIV_W  = 5;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 32;

    logic              clkIn     = 1'b0;
    logic              rst_n     = 1'b0;
    logic [DIV_W-1:0]  clkDevide = '0;
    logic [1:0]        mode      = 2'd1;
    logic [1:0]        mode_w    = 2'd1;
    logic              stepReq   = 1'b0;
    logic [STEP_W-1:0] burstLen  = '0;
    logic              clkEnable = 1'b1;
    logic              clkOut, tickEn, busy, done;
    logic [CNT_W-1:0]  cycleCount;
    logic              w_clkOut, w_tickEn, w_busy, w_done;
    logic [3:0]        w_cycleCount;

    always #5 clkIn = ~clkIn;

    sm_clk_ctrl #(.DIV_W(DIV_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .clkIn(clkIn), .rst_n(rst_n), .clkDevide(clkDevide), .mode(mode),
        .stepReq(stepReq), .burstLen(burstLen), .clkEnable(clkEnable),
        .clkOut(clkOut), .tickEn(tickEn), .busy(busy), .done(done), .cycleCount(cycleCount)
    );

    // Narrow counter instance so the wrap-around is reachable in a short run.
    sm_clk_ctrl #(.DIV_W(DIV_W), .STEP_W(STEP_W), .CNT_W(4)) dut_w (
        .clkIn(clkIn), .rst_n(rst_n), .clkDevide(clkDevide), .mode(mode_w),
        .stepReq(stepReq), .burstLen(burstLen), .clkEnable(clkEnable),
        .clkOut(w_clkOut), .tickEn(w_tickEn), .busy(w_busy), .done(w_done), .cycleCount(w_cycleCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int   mon_rises = 0, mon_dones = 0, mon_done_tick = 0;
    logic mon_prev  = 1'b0;
    always @(negedge clkIn) begin
        if (clkOut && !mon_prev) mon_rises <= mon_rises + 1;
        if (done) mon_dones <= mon_dones + 1;
        if (done && tickEn) mon_done_tick <= mon_done_tick + 1;
        mon_prev <= clkOut;
    end

    task automatic step1();
        @(posedge clkIn);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step1();
        rst_n = 1'b1;
    endtask

    task automatic wait_rise(input string nm);
        logic p;
        bit   ok;
        ok = 1'b0;
        p  = clkOut;
        for (int i = 0; i < 40; i++) begin
            step1();
            if (clkOut && !p) begin
                ok = 1'b1;
                break;
            end
            p = clkOut;
        end
        check(nm, ok, 1);
    endtask

    typedef struct {
        logic [1:0]        mode;
        logic              en;
        logic [STEP_W-1:0] bl;
        logic [DIV_W-1:0]  div;
        int                rises;
        int                dones;
    } vec_t;
    vec_t vecs[6];

    // Reference model: an owner mode holding a budget of core edges plus a phase timer.
    bit          m_clk;
    int          m_left, m_owner, m_edges;
    logic [31:0] m_cnt;
    logic [2:0]  m_sh;

    task automatic model_init();
        m_clk = 0; m_left = 0; m_owner = -1; m_edges = 0; m_cnt = '0; m_sh = '0;
    endtask

    task automatic model_cycle();
        bit edge_s, fire, allowed, tick, exp_done, exp_busy;
        int md, nxt;
        md       = int'(mode);
        edge_s   = m_sh[1] & ~m_sh[2];
        fire     = (m_left == 0) && !m_clk;
        allowed  = (m_owner >= 0) && clkEnable && (md == m_owner);
        tick     = fire && allowed;
        exp_busy = (m_owner >= 0) && clkEnable && (md != 1);
        exp_done = 0;
        if (m_owner < 0 && md == 3 && edge_s && burstLen == '0) exp_done = 1;
        if (tick && m_owner > 0 && m_edges == 1) exp_done = 1;
        check("rnd_clkOut", clkOut, m_clk);
        check("rnd_tickEn", tickEn, tick);
        check("rnd_busy", busy, exp_busy);
        check("rnd_done", done, exp_done);
        check("rnd_cycleCount", cycleCount, m_cnt);
        nxt = m_owner;
        if (m_owner < 0) begin
            if (md == 0 && clkEnable) nxt = 0;
            else if (edge_s && md == 2) begin nxt = 2; m_edges = 1; end
            else if (edge_s && md == 3 && burstLen != '0) begin nxt = 3; m_edges = int'(burstLen); end
        end else if (m_owner == 0) begin
            if (fire && !allowed) nxt = -1;
        end else begin
            if (tick) begin
                m_edges--;
                if (m_edges == 0) nxt = -1;
            end else if (md != m_owner && md != 1) begin
                nxt = -1;
            end
        end
        m_owner = nxt;
        if (m_left > 0) m_left--;
        else if (m_clk) begin m_clk = 0; m_left = int'(clkDevide); end
        else if (tick) begin m_clk = 1; m_left = int'(clkDevide); m_cnt = m_cnt + 1; end
        m_sh = {m_sh[1:0], stepReq};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, br, bd, bt, r;
        bit ok;
        logic [CNT_W-1:0] bc;

        vecs[0] = '{2'd2, 1'b1, 16'd0, 5'd0, 1, 1};
        vecs[1] = '{2'd3, 1'b1, 16'd5, 5'd1, 5, 1};
        vecs[2] = '{2'd3, 1'b1, 16'd0, 5'd2, 0, 1};
        vecs[3] = '{2'd3, 1'b1, 16'd3, 5'd0, 3, 1};
        vecs[4] = '{2'd1, 1'b1, 16'd4, 5'd0, 0, 0};
        vecs[5] = '{2'd0, 1'b0, 16'd2, 5'd1, 0, 0};

        #12;
        check("rst_clkOut", clkOut, 0);
        check("rst_tickEn", tickEn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cycleCount", cycleCount, 0);
        step1();
        rst_n = 1'b1;

        // RUN, divide 0: period 2, ten ticks
        mode = 2'd0; clkDevide = 5'd0; clkEnable = 1'b1;
        for (int i = 0; i < 100 && mon_rises < 10; i++) step1();
        check("run0_cycleCount", cycleCount, 10);
        begin
            logic p;
            n = 0;
            p = clkOut;
            repeat (8) begin
                step1();
                if (clkOut != p) n++;
                p = clkOut;
            end
            check("run0_toggles", n, 8);
        end

        // RUN, divide 3: 4 high / 4 low, then HALT mid-high
        clkDevide = 5'd3;
        repeat (20) step1();
        wait_rise("d3_rise");
        n = 1;
        for (int i = 0; i < 20; i++) begin step1(); if (!clkOut) break; n++; end
        check("d3_high", n, 4);
        n = 1;
        for (int i = 0; i < 20; i++) begin step1(); if (clkOut) break; n++; end
        check("d3_low", n, 4);
        step1();
        mode = 2'd1;
        n = 2;
        #1 check("halt_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin step1(); if (!clkOut) break; n++; end
        check("halt_high", n, 4);
        br = mon_rises;
        repeat (30) step1();
        check("halt_rises", mon_rises - br, 0);
        check("halt_clkOut", clkOut, 0);
        check("halt_busy2", busy, 0);

        // STEP latency and ignored re-trigger while a step is pending
        mode = 2'd2;
        step1();
        br = mon_rises; bd = mon_dones;
        stepReq = 1'b1;
        step1(); check("lat_k_tick", tickEn, 0);
        step1(); check("lat_k1_tick", tickEn, 0);
        step1(); check("lat_k2_tick", tickEn, 1);
        check("lat_k2_done", done, 1);
        check("lat_k2_clk", clkOut, 0);
        step1(); check("lat_k3_clk", clkOut, 1);
        check("lat_k3_busy", busy, 0);
        stepReq = 1'b0; step1();
        stepReq = 1'b1; step1();
        stepReq = 1'b0; step1();
        stepReq = 1'b1;
        repeat (40) step1();
        stepReq = 1'b0;
        repeat (5) step1();
        check("step_rises", mon_rises - br, 2);
        check("step_dones", mon_dones - bd, 2);

        // Table of one-shot requests from park
        foreach (vecs[v]) begin
            mode = 2'd1; clkEnable = 1'b1;
            repeat (4) step1();
            clkDevide = vecs[v].div; burstLen = vecs[v].bl;
            mode = vecs[v].mode; clkEnable = vecs[v].en;
            step1();
            br = mon_rises; bd = mon_dones; bt = mon_done_tick; bc = cycleCount;
            stepReq = 1'b1; step1(); stepReq = 1'b0;
            repeat (100) step1();
            check($sformatf("vec%0d_rises", v), mon_rises - br, vecs[v].rises);
            check($sformatf("vec%0d_dones", v), mon_dones - bd, vecs[v].dones);
            check($sformatf("vec%0d_done_tick", v), mon_done_tick - bt,
                  (vecs[v].rises > 0) ? vecs[v].dones : 0);
            check($sformatf("vec%0d_count", v), cycleCount - bc, vecs[v].rises);
            check($sformatf("vec%0d_busy", v), busy, 0);
        end
        mode = 2'd1; clkEnable = 1'b1;

        // BURST of 8 paused by clkEnable after 3 edges
        repeat (4) step1();
        clkDevide = 5'd1; burstLen = 16'd8; mode = 2'd3;
        step1();
        br = mon_rises; bd = mon_dones; bc = cycleCount;
        stepReq = 1'b1; step1(); stepReq = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mon_rises - br >= 3) begin ok = 1'b1; break; end
            step1();
        end
        check("bp_three", ok, 1);
        clkEnable = 1'b0;
        repeat (20) step1();
        check("bp_pause_rises", mon_rises - br, 3);
        check("bp_pause_clk", clkOut, 0);
        check("bp_pause_busy", busy, 0);
        clkEnable = 1'b1;
        repeat (60) step1();
        check("bp_rises", mon_rises - br, 8);
        check("bp_dones", mon_dones - bd, 1);
        check("bp_count", cycleCount - bc, 8);

        // Counter wrap on the narrow instance
        mode = 2'd1;
        do_reset();
        mode_w = 2'd0; clkDevide = 5'd0;
        for (int i = 0; i < 100 && w_cycleCount != 4'hF; i++) step1();
        check("wrap_allones", w_cycleCount, 15);
        for (int i = 0; i < 10 && w_cycleCount == 4'hF; i++) step1();
        check("wrap_zero", w_cycleCount, 0);
        mode_w = 2'd1;

        // Asynchronous reset during a high phase
        mode = 2'd0; clkDevide = 5'd3; clkEnable = 1'b1;
        wait_rise("arst_rise");
        #2 rst_n = 1'b0;
        #1;
        check("arst_clkOut", clkOut, 0);
        check("arst_tickEn", tickEn, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cycleCount", cycleCount, 0);
        step1();
        rst_n = 1'b1;

        // Randomized run against the reference model
        model_init();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                r = $urandom_range(19);
                mode = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
            end
            if ($urandom_range(15) == 0) clkEnable = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0) stepReq = ~stepReq;
            if ($urandom_range(9) == 0) clkDevide = DIV_W'($urandom_range(3));
            if ($urandom_range(9) == 0) burstLen = STEP_W'($urandom_range(4));
            #1;
            model_cycle();
            step1();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
